keypad_controller: RTL and testbench
====================================

Name: keypad_controller

Overview:
- Memory-mapped key-input peripheral that sits upstream of the interrupt controller and the CPU read-data mux.
- Synchronises and debounces the 8 raw active-low button lines (A, B, C, Up, Down, Left, Right, Power).
- Exposes the debounced state and configuration registers on the shared CPU bus.
- Emits one-cycle key IRQ pulses that feed the irq block's irqs vector at positions 0x15–0x1C.

Parameters:
- CLK_DIV, 4096, clk cycles per debounce sample tick (≥2).
- BASE_ADDR, 24'h2050, bus address of the first register.

Ports:
- clk  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- bus_write  in  1  CPU write strobe for the current bus cycle.
- bus_read  in  1  CPU read strobe.
- bus_address_in  in  24  bus address.
- bus_data_in  in  8  write data.
- bus_data_out  out  8  read data; 0 when no register is addressed (OR-combined bus).
- keys_n  in  8  raw asynchronous button inputs, 0 = pressed; bit0 A … bit7 Power.
- irq_keys  out  8  per-key one-cycle interrupt pulses.

Behaviour:
- Register map, at BASE_ADDR+offset:
  - +0 KEY_EDGE (RW, reset 8'h00): bit i=1 raises IRQ on both press and release of key i; bit i=0 raises on press only.
  - +2 KEY_PAD (RO, reset 8'hFF): debounced state, 0 = pressed.
  - +4 KEY_DEB (RW, reset 8'h03): bits[3:0] = N, the stable-tick count; bits[7:4] read 0 and writes to them are ignored.
- Reads: bus_data_out is combinational from bus_address_in. The matching register value is returned independent of bus_read; every other address returns 8'h00. Writes to KEY_PAD are ignored.
- Writes: a register updates at the posedge where bus_write=1 and the address matches. The new value is visible on the next cycle.
- Synchroniser: 2-flop chain per bit, reset to 1. sync = output of the second flop.
- Tick generator: a counter of width clog2(CLK_DIV) counts 0..CLK_DIV-1 and wraps. tick=1 for one cycle at the wrap. Reset value 0.
- Debounce, per key i, with a 4-bit counter cnt_i (reset 0):
  - N=0 (bypass): deb_i <= sync_i every clock. cnt_i is held at 0.
  - N>0, sync_i == deb_i: cnt_i <= 0.
  - N>0, sync_i != deb_i, on tick: if cnt_i+1 == N then deb_i <= sync_i and cnt_i <= 0; otherwise cnt_i <= cnt_i+1.
  - N>0, sync_i != deb_i, no tick: cnt_i holds.
  - The counter never exceeds N-1, so no wrap is possible.
  - A write to KEY_DEB clears all cnt_i in the same cycle. The write has priority over a coincident tick.
- Press latency: at most 2 clk of sync plus N ticks.
- IRQ:
  - irq_keys[i] = 1 for exactly one clk, in the cycle after deb_i changes from 1 to 0.
  - If KEY_EDGE[i]=1, a 0 to 1 change also pulses.
  - Edge detection uses a registered copy deb_q (reset 8'hFF). Because deb_q resets to 8'hFF, a key held through reset produces a press IRQ once debounced.
  - Multiple keys changing in the same cycle produce simultaneous pulses on their own bits.
- Reset asserted mid-operation: all state returns to its reset value immediately and asynchronously. irq_keys=0 and bus_data_out reflects the reset register values.
- Reset values, summarised: irq_keys=0. bus_data_out reflects reset register contents per address (e.g. 8'hFF at +2).

Decomposition:
- Shared peripheral package holds:
  - register offset constants KEY_EDGE_OFS=0, KEY_PAD_OFS=2, KEY_DEB_OFS=4;
  - key bit index constants KEY_A … KEY_POWER;
  - the key IRQ base index 5'h15, used by the top level to wire irqs[5'h15 + i].
- One sub-module is natural: key_debounce, a single-bit synchroniser plus counter and deb flop. It takes tick, N and clear, outputs deb, and is instantiated 8 times.

Test Plan:
1. Reset: reset=0 then 1, keys_n=8'hFF → read 2052 = 8'hFF, 2054 = 8'h03, 2050 = 8'h00, irq_keys=0; read 2051 = 8'h00.
2. Press A, CLK_DIV=4, N=3: keys_n[0]=0 held → KEY_PAD=8'hFE within 2+12 clk (±1 tick phase). irq_keys[0] pulses exactly one cycle; no pulse on release.
3. Bounce: keys_n[2] toggles every 5 clk for 40 clk, then stays 0 → no IRQ during bounce; exactly one irq_keys[2] pulse after it settles.
4. Both-edge mode: write 2050=8'h80, press then release Power → two pulses on irq_keys[7]. Write 2054=8'hF5 → reads back 8'h05.
5. Bypass: write 2054=8'h00, press Up (bit3) → KEY_PAD bit3=0 within 3 clk, followed by one pulse. Simultaneous press of bits 1 and 4 → both irq bits pulse in the same cycle.
6. Mid-debounce reset and KEY_DEB write: assert reset while cnt is partway → KEY_PAD=8'hFF, no IRQ. Writing KEY_DEB during counting restarts the full N-tick wait.

Source files
------------

// File: rtl/keypad_controller_pkg.sv
// Shared definitions for the key-input peripheral: register offsets, key bit
// positions and the location of the key lines in the system IRQ vector.
package keypad_controller_pkg;

  localparam logic [23:0] KEY_EDGE_OFS = 24'd0;
  localparam logic [23:0] KEY_PAD_OFS  = 24'd2;
  localparam logic [23:0] KEY_DEB_OFS  = 24'd4;

  localparam int KEY_A     = 0;
  localparam int KEY_B     = 1;
  localparam int KEY_C     = 2;
  localparam int KEY_UP    = 3;
  localparam int KEY_DOWN  = 4;
  localparam int KEY_LEFT  = 5;
  localparam int KEY_RIGHT = 6;
  localparam int KEY_POWER = 7;
  localparam int NUM_KEYS  = KEY_POWER + 1;

  localparam logic [3:0] KEY_DEB_RESET = 4'd3;

  // Key i drives irqs[KEY_IRQ_BASE + i] in the interrupt controller.
  localparam logic [4:0] KEY_IRQ_BASE = 5'h15;

  function automatic logic [4:0] key_irq_index(input logic [2:0] key);
    return KEY_IRQ_BASE + 5'(key);
  endfunction

endpackage

// File: rtl/keypad_controller_key_debounce.sv
// One key line: two-flop synchroniser followed by a tick-counted debounce.
// N=0 bypasses the counter and follows the synchronised input directly.
module keypad_controller_key_debounce (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  input  logic       tick,
  input  logic [3:0] n,
  input  logic       clear,
  output logic       deb
);

  logic       sync_p0;
  logic       sync_p1;
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
    end
  end

  // cnt only runs while the synchronised input disagrees with deb, and a
  // KEY_DEB write restarts the wait even if a tick lands in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb <= 1'b1;
      cnt <= 4'd0;
    end else if (n == 4'd0) begin
      deb <= sync_p1;
      cnt <= 4'd0;
    end else if (clear || (sync_p1 == deb)) begin
      cnt <= 4'd0;
    end else if (tick) begin
      if (cnt + 4'd1 == n) begin
        deb <= sync_p1;
        cnt <= 4'd0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/keypad_controller.sv
// Memory-mapped keypad peripheral: debounced key state, edge configuration
// and per-key one-cycle IRQ pulses for the interrupt controller.
module keypad_controller
  import keypad_controller_pkg::*;
#(
  parameter int          CLK_DIV   = 4096,
  parameter logic [23:0] BASE_ADDR = 24'h2050
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_write,
  input  logic        bus_read,
  input  logic [23:0] bus_address_in,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  input  logic [7:0]  keys_n,
  output logic [7:0]  irq_keys
);

  localparam int          TICK_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [23:0] ADDR_EDGE = BASE_ADDR + KEY_EDGE_OFS;
  localparam logic [23:0] ADDR_PAD  = BASE_ADDR + KEY_PAD_OFS;
  localparam logic [23:0] ADDR_DEB  = BASE_ADDR + KEY_DEB_OFS;

  logic [TICK_W-1:0]   tick_cnt;
  logic                tick;
  logic [7:0]          key_edge;
  logic [3:0]          key_deb_n;
  logic                sel_edge;
  logic                sel_pad;
  logic                sel_deb;
  logic                deb_clear;
  logic [NUM_KEYS-1:0] deb;
  logic [NUM_KEYS-1:0] deb_q;
  logic [4:0]          unused_bus_bits;

  // Reads are decoded from the address alone; the strobe and the upper
  // KEY_DEB data bits carry no information here.
  assign unused_bus_bits = {bus_read, bus_data_in[7:4]};

  assign tick = (tick_cnt == TICK_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TICK_W'(1);
  end

  assign sel_edge  = (bus_address_in == ADDR_EDGE);
  assign sel_pad   = (bus_address_in == ADDR_PAD);
  assign sel_deb   = (bus_address_in == ADDR_DEB);
  assign deb_clear = bus_write && sel_deb;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_edge  <= 8'h00;
      key_deb_n <= KEY_DEB_RESET;
    end else if (bus_write) begin
      if (sel_edge) key_edge  <= bus_data_in;
      if (sel_deb)  key_deb_n <= bus_data_in[3:0];
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    keypad_controller_key_debounce u_debounce (
      .clk   (clk),
      .reset (reset),
      .key_n (keys_n[i]),
      .tick  (tick),
      .n     (key_deb_n),
      .clear (deb_clear),
      .deb   (deb[i])
    );
  end

  // deb_q resets to all-released so a key held through reset still raises
  // its press IRQ once it has been debounced.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_q    <= 8'hFF;
      irq_keys <= 8'h00;
    end else begin
      deb_q    <= deb;
      irq_keys <= (deb_q & ~deb) | (key_edge & ~deb_q & deb);
    end
  end

  always_comb begin
    bus_data_out = 8'h00;
    if (sel_edge)     bus_data_out = key_edge;
    else if (sel_pad) bus_data_out = deb;
    else if (sel_deb) bus_data_out = {4'h0, key_deb_n};
  end

endmodule

// File: tb/tb_keypad_controller.sv
// Bench for keypad_controller: directed scenarios plus a random phase, all
// checked every cycle against a register-level model of the peripheral.
module tb_keypad_controller;

  localparam int          CLK_DIV = 4;
  localparam logic [23:0] BASE    = 24'h2050;

  logic        clk;
  logic        reset;
  logic        bus_write;
  logic        bus_read;
  logic [23:0] bus_address_in;
  logic [7:0]  bus_data_in;
  logic [7:0]  bus_data_out;
  logic [7:0]  keys_n;
  logic [7:0]  irq_keys;

  keypad_controller #(.CLK_DIV(CLK_DIV), .BASE_ADDR(BASE)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus_write      (bus_write),
    .bus_read       (bus_read),
    .bus_address_in (bus_address_in),
    .bus_data_in    (bus_data_in),
    .bus_data_out   (bus_data_out),
    .keys_n         (keys_n),
    .irq_keys       (irq_keys)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: raw-key history (two samples), debounced keys, previous
  // debounced keys, ticks seen while disagreeing, and the two RW registers.
  logic [7:0] m_s1, m_s2, m_deb, m_deb_q, m_irq, m_edge;
  logic [3:0] m_n;
  int         m_tcnt;
  int         m_ticks [8];

  logic       m_tick, m_wr_deb, m_wr_edge;
  logic [7:0] nx_deb, nx_irq;
  int         nx_ticks [8];

  always_comb begin
    m_tick    = ((m_tcnt % CLK_DIV) == CLK_DIV - 1);
    m_wr_deb  = bus_write && (bus_address_in == BASE + 24'd4);
    m_wr_edge = bus_write && (bus_address_in == BASE);
    nx_deb    = m_deb;
    nx_ticks  = m_ticks;
    for (int i = 0; i < 8; i++) begin
      if (m_n == 4'd0) begin
        nx_deb[i]   = m_s2[i];
        nx_ticks[i] = 0;
      end else if (m_wr_deb || (m_s2[i] == m_deb[i])) begin
        nx_ticks[i] = 0;
      end else if (m_tick) begin
        nx_ticks[i] = m_ticks[i] + 1;
        if (nx_ticks[i] == int'(m_n)) begin
          nx_deb[i]   = m_s2[i];
          nx_ticks[i] = 0;
        end
      end
    end
    nx_irq = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (m_deb_q[i] && !m_deb[i]) nx_irq[i] = 1'b1;
      if (m_edge[i] && !m_deb_q[i] && m_deb[i]) nx_irq[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_s1 <= 8'hFF; m_s2 <= 8'hFF; m_deb <= 8'hFF; m_deb_q <= 8'hFF;
      m_irq <= 8'h00; m_edge <= 8'h00; m_n <= 4'd3; m_tcnt <= 0;
      for (int i = 0; i < 8; i++) m_ticks[i] <= 0;
    end else begin
      m_tcnt  <= (m_tcnt + 1) % CLK_DIV;
      m_s1    <= keys_n;
      m_s2    <= m_s1;
      m_deb   <= nx_deb;
      m_deb_q <= m_deb;
      m_irq   <= nx_irq;
      m_ticks <= nx_ticks;
      if (m_wr_edge) m_edge <= bus_data_in;
      if (m_wr_deb)  m_n    <= bus_data_in[3:0];
    end
  end

  function automatic logic [7:0] model_read(input logic [23:0] a);
    if (a == BASE)          return m_edge;
    if (a == BASE + 24'd2)  return m_deb;
    if (a == BASE + 24'd4)  return {4'h0, m_n};
    return 8'h00;
  endfunction

  int n_cmp = 0;
  int n_err = 0;
  int tot [8];
  int both_tot = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance n clocks; after each edge compare outputs with the model and
  // tally IRQ pulses for the directed pulse-count checks.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      check8("irq_keys", irq_keys, m_irq);
      check8("bus_data_out", bus_data_out, model_read(bus_address_in));
      for (int i = 0; i < 8; i++) tot[i] += int'(irq_keys[i]);
      if (irq_keys[1] && irq_keys[4]) both_tot++;
    end
  endtask

  task automatic rd(input string name, input logic [23:0] a, input logic [7:0] exp);
    bus_address_in = a;
    #1;
    check8(name, bus_data_out, exp);
  endtask

  task automatic wr(input logic [23:0] a, input logic [7:0] d);
    bus_address_in = a;
    bus_data_in    = d;
    bus_write      = 1'b1;
    step(1);
    bus_write      = 1'b0;
  endtask

  int base;

  initial begin
    for (int i = 0; i < 8; i++) tot[i] = 0;
    reset = 1'b0; bus_write = 1'b0; bus_read = 1'b0;
    bus_address_in = 24'h0; bus_data_in = 8'h00; keys_n = 8'hFF;
    step(3);
    reset = 1'b1;
    step(2);

    rd("reset_pad", BASE + 24'd2, 8'hFF);
    rd("reset_deb", BASE + 24'd4, 8'h03);
    rd("reset_edge", BASE, 8'h00);
    rd("reset_gap", BASE + 24'd1, 8'h00);
    check8("reset_irq", irq_keys, 8'h00);

    // Press and release A with N=3
    base = tot[0];
    keys_n[0] = 1'b0;
    step(20);
    rd("press_a_pad", BASE + 24'd2, 8'hFE);
    check_int("press_a_pulses", tot[0] - base, 1);
    keys_n[0] = 1'b1;
    step(20);
    check_int("release_a_no_pulse", tot[0] - base, 1);
    rd("release_a_pad", BASE + 24'd2, 8'hFF);

    // Bounce on C, then settle pressed
    base = tot[2];
    for (int k = 0; k < 8; k++) begin
      keys_n[2] = ~keys_n[2];
      step(5);
    end
    check_int("bounce_no_pulse", tot[2] - base, 0);
    keys_n[2] = 1'b0;
    step(20);
    check_int("bounce_settled_pulse", tot[2] - base, 1);
    rd("bounce_pad", BASE + 24'd2, 8'hFB);
    keys_n[2] = 1'b1;
    step(20);

    // Both-edge mode on Power
    wr(BASE, 8'h80);
    base = tot[7];
    keys_n[7] = 1'b0;
    step(20);
    keys_n[7] = 1'b1;
    step(20);
    check_int("both_edge_pulses", tot[7] - base, 2);
    wr(BASE + 24'd4, 8'hF5);
    rd("deb_upper_masked", BASE + 24'd4, 8'h05);
    wr(BASE, 8'h00);

    // Bypass mode
    wr(BASE + 24'd4, 8'h00);
    base = tot[3];
    keys_n[3] = 1'b0;
    step(3);
    rd("bypass_pad", BASE + 24'd2, 8'hF7);
    step(2);
    check_int("bypass_pulse", tot[3] - base, 1);
    keys_n[3] = 1'b1;
    step(5);
    base = both_tot;
    keys_n = 8'hED;
    step(6);
    check_int("simultaneous_pulse", both_tot - base, 1);
    keys_n = 8'hFF;
    step(6);

    // Reset in the middle of a debounce
    wr(BASE + 24'd4, 8'h03);
    step(20);
    keys_n[0] = 1'b0;
    step(8);
    reset = 1'b0;
    rd("midreset_pad", BASE + 24'd2, 8'hFF);
    check8("midreset_irq", irq_keys, 8'h00);
    keys_n = 8'hFF;
    step(2);
    reset = 1'b1;
    base = tot[0];
    step(20);
    check_int("midreset_no_pulse", tot[0] - base, 0);
    rd("midreset_pad_after", BASE + 24'd2, 8'hFF);

    // KEY_DEB write restarts an in-progress debounce
    keys_n[1] = 1'b0;
    step(6);
    wr(BASE + 24'd4, 8'h03);
    step(8);
    rd("deb_restart_wait", BASE + 24'd2, 8'hFF);
    step(12);
    rd("deb_restart_done", BASE + 24'd2, 8'hFD);
    keys_n = 8'hFF;
    step(20);

    // Random phase
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 15) == 0) keys_n = keys_n ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0)
        bus_address_in = BASE + 24'($urandom_range(0, 6));
      else
        bus_address_in = 24'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        bus_address_in = BASE + 24'(2 * $urandom_range(0, 2));
        bus_data_in    = 8'($urandom);
        bus_write      = 1'b1;
      end else begin
        bus_write      = 1'b0;
      end
      bus_read = 1'($urandom);
      step(1);
    end
    bus_write = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
